apuf_eval_ctrl: RTL and testbench



---
 rtl/apuf_eval_pkg.sv | 36 +++
 rtl/apuf_vote_ch.sv | 61 ++++++
 rtl/apuf_eval_ctrl.sv | 178 +++++++++++++++++
 tb/tb_apuf_eval_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apuf_eval_pkg.sv
// Shared state encoding and width helpers for the APUF evaluation controller.
package apuf_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FIRE   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Never return a zero width, so degenerate configurations still elaborate.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int lane_idx_w(input int chal_size);
    return clog2_min1(chal_size / 8);
  endfunction

  function automatic int ones_cnt_w(input int n_rep);
    return clog2_min1(n_rep + 1);
  endfunction

  function automatic int settle_cnt_w(input int settle_cyc);
    return clog2_min1(settle_cyc);
  endfunction

  function automatic int tmo_cnt_w(input int timeout_cyc);
    return clog2_min1(timeout_cyc);
  endfunction

  localparam int DEF_LANE_IDX_W = lane_idx_w(64);
  localparam int DEF_ONES_W     = ones_cnt_w(5);
  localparam int DEF_TMO_W      = tmo_cnt_w(255);

endpackage

// File: rtl/apuf_vote_ch.sv
// One APUF channel: first-ready capture per rep, ones counter, majority vote.
module apuf_vote_ch
  import apuf_eval_pkg::*;
#(
  parameter int N_REP = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic fire,
  input  logic rep_end,
  input  logic ready_in,
  input  logic bit_in,
  output logic rdy_o,
  output logic vote_o
);

  localparam int ONES_W = ones_cnt_w(N_REP);

  logic              captured_q, captured_d;
  logic              bit_q, bit_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [ONES_W-1:0] ones_nxt;
  logic              bit_eff;

  always_comb begin
    // A channel still unready when the rep ends (timeout) contributes 0.
    bit_eff    = captured_q ? bit_q : (ready_in & bit_in);
    ones_nxt   = ones_q + ONES_W'(bit_eff);
    rdy_o      = captured_q | ready_in;
    vote_o     = (ones_nxt > ONES_W'(N_REP / 2));
    captured_d = captured_q;
    bit_d      = bit_q;
    ones_d     = ones_q;
    if (clr) begin
      captured_d = 1'b0;
      ones_d     = '0;
    end else if (rep_end) begin
      captured_d = 1'b0;
      ones_d     = ones_nxt;
    end else if (fire && ready_in && !captured_q) begin
      captured_d = 1'b1;
      bit_d      = bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      captured_q <= 1'b0;
      ones_q     <= '0;
    end else begin
      captured_q <= captured_d;
      ones_q     <= ones_d;
    end
  end

  always_ff @(posedge clk) begin
    bit_q <= bit_d;
  end

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Multi-channel, repeated-evaluation APUF controller with majority voting.
// Optional FIRE timeout enabled by defining APUF_EVAL_TIMEOUT_EN.
module apuf_eval_ctrl
  import apuf_eval_pkg::*;
#(
  parameter int CHAL_SIZE   = 64,
  parameter int N_PUF       = 8,
  parameter int N_REP       = 5,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        chal_byte_in,
  input  logic [lane_idx_w(CHAL_SIZE)-1:0]  chal_byte_idx,
  input  logic                              chal_byte_we,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [CHAL_SIZE-1:0]              challenge,
  output logic                              tig_signal,
  input  logic [N_PUF-1:0]                  resp_ready_in,
  input  logic [N_PUF-1:0]                  resp_bit_in,
  output logic [N_PUF-1:0]                  resp_word,
  output logic                              timeout_err
);

  localparam int LANES = CHAL_SIZE / 8;
  localparam int SET_W = settle_cnt_w(SETTLE_CYC);
  localparam int REP_W = ones_cnt_w(N_REP);

  state_e                 state_q, state_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [REP_W-1:0]       rep_q, rep_d;
  logic [CHAL_SIZE-1:0]   chal_q, chal_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tig_q, tig_d;
  logic [N_PUF-1:0]       resp_q, resp_d;

  logic                   clr, fire, rep_end, all_rdy, tmo_hit;
  logic [N_PUF-1:0]       rdy_vec, vote_vec;

`ifdef APUF_EVAL_TIMEOUT_EN
  localparam int TMO_W = tmo_cnt_w(TIMEOUT_CYC);
  logic [TMO_W-1:0] fire_cnt_q, fire_cnt_d;
  logic             tmo_err_q, tmo_err_d;
  assign tmo_hit     = (fire_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
  assign timeout_err = tmo_err_q;
`else
  wire unused_tmo_cfg = |TIMEOUT_CYC;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign all_rdy = &rdy_vec;
  assign clr     = (state_q == ST_IDLE) && start;
  assign fire    = (state_q == ST_FIRE);
  assign rep_end = fire && (all_rdy || tmo_hit);

  for (genvar g = 0; g < N_PUF; g++) begin : g_ch
    apuf_vote_ch #(.N_REP(N_REP)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .fire     (fire),
      .rep_end  (rep_end),
      .ready_in (resp_ready_in[g]),
      .bit_in   (resp_bit_in[g]),
      .rdy_o    (rdy_vec[g]),
      .vote_o   (vote_vec[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    rep_d    = rep_q;
    chal_d   = chal_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tig_d    = tig_q;
    resp_d   = resp_q;
`ifdef APUF_EVAL_TIMEOUT_EN
    fire_cnt_d = fire_cnt_q;
    tmo_err_d  = tmo_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The write lands even when start arrives in the same cycle.
        if (chal_byte_we && (int'(chal_byte_idx) < LANES))
          chal_d[int'(chal_byte_idx)*8 +: 8] = chal_byte_in;
        if (start) begin
          state_d  = ST_SETTLE;
          busy_d   = 1'b1;
          settle_d = '0;
          rep_d    = '0;
`ifdef APUF_EVAL_TIMEOUT_EN
          tmo_err_d = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = ST_FIRE;
          tig_d   = 1'b1;
`ifdef APUF_EVAL_TIMEOUT_EN
          fire_cnt_d = '0;
`endif
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_FIRE: begin
`ifdef APUF_EVAL_TIMEOUT_EN
        fire_cnt_d = fire_cnt_q + 1'b1;
        if (tmo_hit && !all_rdy) tmo_err_d = 1'b1;
`endif
        // Dropping the trigger between reps also lets the arbiters relax.
        if (rep_end) begin
          tig_d = 1'b0;
          if (rep_q == REP_W'(N_REP - 1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            resp_d  = vote_vec;
          end else begin
            state_d  = ST_SETTLE;
            rep_d    = rep_q + 1'b1;
            settle_d = '0;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      rep_q    <= '0;
      chal_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tig_q    <= 1'b0;
      resp_q   <= '0;
`ifdef APUF_EVAL_TIMEOUT_EN
      fire_cnt_q <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      rep_q    <= rep_d;
      chal_q   <= chal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tig_q    <= tig_d;
      resp_q   <= resp_d;
`ifdef APUF_EVAL_TIMEOUT_EN
      fire_cnt_q <= fire_cnt_d;
      tmo_err_q  <= tmo_err_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign challenge  = chal_q;
  assign tig_signal = tig_q;
  assign resp_word  = resp_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Scoreboard bench for apuf_eval_ctrl with a behavioural APUF array model.
module tb_apuf_eval_ctrl;

  localparam int CHAL_SIZE   = 64;
  localparam int N_PUF       = 8;
  localparam int N_REP       = 5;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 255;
  localparam int LANES       = CHAL_SIZE / 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           chal_byte_in = '0;
  logic [2:0]           chal_byte_idx = '0;
  logic                 chal_byte_we = 1'b0;
  logic                 start = 1'b0;
  logic                 busy, done, tig_signal, timeout_err;
  logic [CHAL_SIZE-1:0] challenge;
  logic [N_PUF-1:0]     resp_ready_in = '0;
  logic [N_PUF-1:0]     resp_bit_in = '0;
  logic [N_PUF-1:0]     resp_word;

  always #5 clk = ~clk;

  apuf_eval_ctrl #(
    .CHAL_SIZE(CHAL_SIZE), .N_PUF(N_PUF), .N_REP(N_REP),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .chal_byte_in(chal_byte_in), .chal_byte_idx(chal_byte_idx),
    .chal_byte_we(chal_byte_we), .start(start), .busy(busy), .done(done),
    .challenge(challenge), .tig_signal(tig_signal), .resp_ready_in(resp_ready_in),
    .resp_bit_in(resp_bit_in), .resp_word(resp_word), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [N_PUF-1:0] rw;
    logic [63:0]      chal;
    logic             te;
    longint           cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  longint      cyc = 0;
  logic [63:0] chal_m = '0;

  // APUF array configuration: ready latency per channel (-1 = never), bit per rep.
  int               lat[N_PUF];
  logic [N_PUF-1:0] pat[N_REP];
  bit               flip = 1'b0;
  int               m_rep = 0, m_fc = 0, m_r = 0;
  bit               m_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural APUF array: counts trigger-high cycles and reports ready after each latency.
  always @(posedge clk) begin
    #1;
    if (rst || !busy) begin
      m_rep = 0; m_prev = 0; m_fc = 0;
      resp_ready_in = '0;
      resp_bit_in = N_PUF'($urandom);
    end else if (tig_signal) begin
      if (m_prev) m_fc++; else m_fc = 0;
      m_prev = 1;
      m_r = (m_rep < N_REP) ? m_rep : N_REP - 1;
      for (int ch = 0; ch < N_PUF; ch++) begin
        if (lat[ch] >= 0 && m_fc >= lat[ch]) begin
          resp_ready_in[ch] = 1'b1;
          resp_bit_in[ch] = (flip && m_fc > lat[ch]) ? ~pat[m_r][ch] : pat[m_r][ch];
        end else begin
          resp_ready_in[ch] = 1'b0;
          resp_bit_in[ch] = 1'($urandom);
        end
      end
    end else begin
      if (m_prev) m_rep++;
      m_prev = 0;
      resp_ready_in = '0;
      resp_bit_in = N_PUF'($urandom);
    end
  end

  // Reference: majority of first-ready bits per channel; done after N_REP reps of S+L+1 cycles.
  task automatic push_expected(input longint c);
    exp_t e;
    int   big_l;
    big_l = 0;
    e.te = 1'b0;
    e.rw = '0;
    for (int ch = 0; ch < N_PUF; ch++) begin
      bit cap;
      int l, ones;
      cap = (lat[ch] >= 0);
`ifdef APUF_EVAL_TIMEOUT_EN
      cap = cap && (lat[ch] < TIMEOUT_CYC);
`endif
      l = cap ? lat[ch] : TIMEOUT_CYC - 1;
      if (l > big_l) big_l = l;
      if (!cap) e.te = 1'b1;
      ones = 0;
      for (int r = 0; r < N_REP; r++) if (cap && pat[r][ch]) ones++;
      e.rw[ch] = (ones * 2 > N_REP);
    end
    e.chal = chal_m;
    e.cyc = c + longint'(N_REP * (SETTLE_CYC + big_l + 1) + 1);
    sb.push_back(e);
  endtask

  task automatic write_byte(input int idx, input logic [7:0] b);
    chal_byte_we = 1'b1; chal_byte_idx = 3'(idx); chal_byte_in = b;
    chal_m[idx*8 +: 8] = b;
    tick();
    chal_byte_we = 1'b0;
  endtask

  task automatic start_eval(input bit with_we, input int idx, input logic [7:0] b);
    if (with_we) begin
      chal_byte_we = 1'b1; chal_byte_idx = 3'(idx); chal_byte_in = b;
      chal_m[idx*8 +: 8] = b;
    end
    start = 1'b1;
    push_expected(cyc);
    tick();
    start = 1'b0;
    chal_byte_we = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n0;
    bit got;
    n0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done_cnt > n0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no done after %0d cycles, required a done pulse", nm, budget);
      sb.delete();
    end
  endtask

  task automatic set_lat_all(input int l);
    for (int ch = 0; ch < N_PUF; ch++) lat[ch] = l;
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_word", 64'(resp_word), 64'(mon_e.rw));
        chk("challenge", challenge, mon_e.chal);
        chk("timeout_err", 64'(timeout_err), 64'(mon_e.te));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    int n0, rises;
    bit prev_tig;
    set_lat_all(0);
    for (int r = 0; r < N_REP; r++) pat[r] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tig", 64'(tig_signal), 64'd0);
    chk("rst_resp_word", 64'(resp_word), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_challenge", challenge, 64'd0);

    // Directed: bytes 1..8, L=3, stable bits 0xA5.
    for (int i = 0; i < LANES; i++) write_byte(i, 8'(i + 1));
    set_lat_all(3);
    for (int r = 0; r < N_REP; r++) pat[r] = 8'hA5;
    start_eval(0, 0, 8'h00);
    wait_done(200, "t1_done");
    chk("t1_challenge_val", challenge, 64'h0807060504030201);
    chk("t1_resp_val", 64'(resp_word), 64'h00000000000000A5);

    // Channel 0 alternating 1,0,1,0,1 then 0,1,0,1,0.
    for (int ch = 0; ch < N_PUF; ch++) lat[ch] = $urandom_range(0, 4);
    for (int r = 0; r < N_REP; r++) pat[r] = (r % 2 == 0) ? 8'h01 : 8'h00;
    start_eval(0, 0, 8'h00);
    wait_done(200, "t2a_done");
    for (int r = 0; r < N_REP; r++) pat[r] = (r % 2 == 1) ? 8'h01 : 8'h00;
    start_eval(0, 0, 8'h00);
    wait_done(200, "t2b_done");

    // start and a lane-0 write while busy are both ignored.
    set_lat_all(2);
    for (int r = 0; r < N_REP; r++) pat[r] = N_PUF'($urandom);
    n0 = done_cnt;
    start_eval(0, 0, 8'h00);
    repeat (10) tick();
    start = 1'b1; chal_byte_we = 1'b1; chal_byte_idx = 3'd0; chal_byte_in = 8'hFF;
    tick();
    start = 1'b0; chal_byte_we = 1'b0;
    wait_done(200, "t3_done");
    repeat (60) tick();
    chk("t3_single_done", 64'(done_cnt), 64'(n0 + 1));
    chk("t3_challenge", challenge, chal_m);

    // Reset during the third FIRE aborts without a done pulse.
    set_lat_all(1);
    start_eval(0, 0, 8'h00);
    rises = 0;
    prev_tig = 1'b0;
    for (int i = 0; i < 300 && rises < 3; i++) begin
      tick();
      if (tig_signal && !prev_tig) rises++;
      prev_tig = tig_signal;
    end
    chk("t4_third_fire_reached", 64'(rises), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chal_m = '0;
    chk("t4_tig", 64'(tig_signal), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_resp_word", 64'(resp_word), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_challenge", challenge, 64'd0);
    n0 = done_cnt;
    repeat (60) tick();
    chk("t4_no_done", 64'(done_cnt), 64'(n0));
    write_byte(2, 8'h3C);
    for (int r = 0; r < N_REP; r++) pat[r] = N_PUF'($urandom);
    start_eval(1, 5, 8'hC3);
    wait_done(200, "t4_fresh_done");

    // Ready held high with the bit flipping after the first ready cycle.
    set_lat_all(0);
    lat[7] = 4;
    flip = 1'b1;
    for (int r = 0; r < N_REP; r++) pat[r] = N_PUF'($urandom);
    start_eval(0, 0, 8'h00);
    wait_done(200, "t5_done");
    flip = 1'b0;

    // Randomised evaluations, many issued back-to-back.
    for (int it = 0; it < 20; it++) begin
      int nw;
      for (int ch = 0; ch < N_PUF; ch++) lat[ch] = $urandom_range(0, 5);
      for (int r = 0; r < N_REP; r++) pat[r] = N_PUF'($urandom);
      flip = 1'($urandom_range(0, 1));
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_byte($urandom_range(0, LANES - 1), 8'($urandom));
      if ($urandom_range(0, 1) == 1)
        start_eval(1, $urandom_range(0, LANES - 1), 8'($urandom));
      else
        start_eval(0, 0, 8'h00);
      wait_done(300, "rand_done");
    end
    flip = 1'b0;

`ifdef APUF_EVAL_TIMEOUT_EN
    // Channel 3 never ready: rep completes at the timeout, channel 3 votes 0.
    for (int ch = 0; ch < N_PUF; ch++) lat[ch] = $urandom_range(0, 3);
    lat[3] = -1;
    for (int r = 0; r < N_REP; r++) pat[r] = N_PUF'($urandom) | 8'h08;
    start_eval(0, 0, 8'h00);
    wait_done(2000, "tmo_done");
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
    set_lat_all(1);
    start_eval(0, 0, 8'h00);
    chk("tmo_cleared", 64'(timeout_err), 64'd0);
    wait_done(200, "tmo_next_done");
`endif

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
